i2s_tx_tdm: RTL and testbench

//  Parametrised I2S / left-justified / TDM serial audio transmitter clocked from clk_i2s.

---
 rtl/i2s_tx_tdm.sv | 119 +++++++++++
 tb/tb_i2s_tx_tdm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_tdm.sv
// I2S / left-justified / TDM serial audio transmitter with a one-frame input buffer.
// Define I2S_TX_UNDERRUN_REPEAT_EN to resend the last loaded frame on underrun instead of zeros.
module i2s_tx_tdm #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned MODE      = 0,
    parameter int unsigned MCLK_DIV  = 2,
    parameter int unsigned SCLK_DIV  = 8
) (
    input  logic                       clk_i2s,
    input  logic                       reset,
    input  logic [CHANNELS*WIDTH-1:0]  s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       tx_mclk,
    output logic                       tx_sclk,
    output logic                       tx_lrclk,
    output logic                       tx_data,
    output logic                       frame_start,
    output logic                       underrun
);
    localparam int unsigned FRAME_BITS = CHANNELS * SLOT_BITS;
    localparam int unsigned MW = $clog2(MCLK_DIV);
    localparam int unsigned DW = $clog2(SCLK_DIV);
    localparam int unsigned BW = $clog2(FRAME_BITS);

    localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV - 1);
    localparam logic [MW-1:0] MCLK_HALF = MW'(MCLK_DIV / 2);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(SCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] BIT_HALF  = BW'(FRAME_BITS / 2);

    logic [MW-1:0]             mclk_cnt, mclk_cnt_nxt;
    logic [DW-1:0]             div_cnt, div_cnt_nxt;
    logic [BW-1:0]             bit_cnt, bit_cnt_nxt;
    logic [CHANNELS*WIDTH-1:0] buf_data;
    logic [CHANNELS*WIDTH-1:0] load_src;
    logic                      buf_full;
    logic [FRAME_BITS-1:0]     shifter, shifter_nxt, packed_frame;
    logic                      bit_tick, load, accept;

    assign bit_tick = (div_cnt == DIV_LAST);
    assign load     = bit_tick && (bit_cnt == BIT_LAST);
    assign accept   = s_valid && !buf_full;
    assign s_ready  = ~buf_full;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [CHANNELS*WIDTH-1:0] held_data;

    assign load_src = buf_full ? buf_data : held_data;

    always_ff @(posedge clk_i2s or posedge reset) begin
        if (reset) begin
            held_data <= '0;
        end else if (load && buf_full) begin
            held_data <= buf_data;
        end
    end
`else
    assign load_src = buf_full ? buf_data : '0;
`endif

    // Shifter holds the whole frame MSB-first; each slot is sample then zero padding.
    always_comb begin
        packed_frame = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            packed_frame[FRAME_BITS-1-ch*SLOT_BITS -: WIDTH] = load_src[ch*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        mclk_cnt_nxt = (mclk_cnt == MCLK_LAST) ? '0 : mclk_cnt + 1'b1;
        div_cnt_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        bit_cnt_nxt  = bit_cnt;
        shifter_nxt  = shifter;
        if (bit_tick) begin
            bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            shifter_nxt = load ? packed_frame : {shifter[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i2s or posedge reset) begin
        if (reset) begin
            mclk_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= BIT_LAST;
            shifter     <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            tx_mclk     <= 1'b0;
            tx_sclk     <= 1'b0;
            tx_lrclk    <= 1'b1;
            tx_data     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            mclk_cnt    <= mclk_cnt_nxt;
            div_cnt     <= div_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shifter     <= shifter_nxt;
            tx_mclk     <= (mclk_cnt_nxt >= MCLK_HALF);
            tx_sclk     <= (div_cnt_nxt >= DIV_HALF);
            frame_start <= load;
            underrun    <= load && !buf_full;
            // A load on an empty buffer can coincide with an accept; the accept wins.
            buf_full    <= (buf_full && !load) || accept;
            if (accept) begin
                buf_data <= s_data;
            end
            if (bit_tick) begin
                tx_lrclk <= (bit_cnt_nxt >= BIT_HALF);
                // I2S delays the serial stream by one bit via the old shifter MSB.
                tx_data  <= (MODE == 1) ? shifter_nxt[FRAME_BITS-1] : shifter[FRAME_BITS-1];
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_tdm.sv
// Directed bench for i2s_tx_tdm: I2S, left-justified and 8-slot TDM instances on one clock.
module tb_i2s_tx_tdm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [47:0]   s_data;
    logic          s_valid;
    logic [127:0]  s_data8;
    logic          s_valid8;

    logic s_ready0, tx_mclk0, tx_sclk0, tx_lrclk0, tx_data0, fs0, ur0;
    logic s_ready1, tx_mclk1, tx_sclk1, tx_lrclk1, tx_data1, fs1, ur1;
    logic s_ready8, tx_mclk8, tx_sclk8, tx_lrclk8, tx_data8, fs8, ur8;

    i2s_tx_tdm #(.WIDTH(24), .SLOT_BITS(32), .CHANNELS(2), .MODE(0), .MCLK_DIV(2), .SCLK_DIV(8)) dut0 (
        .clk_i2s(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
        .tx_mclk(tx_mclk0), .tx_sclk(tx_sclk0), .tx_lrclk(tx_lrclk0), .tx_data(tx_data0),
        .frame_start(fs0), .underrun(ur0));

    i2s_tx_tdm #(.WIDTH(24), .SLOT_BITS(32), .CHANNELS(2), .MODE(1), .MCLK_DIV(2), .SCLK_DIV(8)) dut1 (
        .clk_i2s(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
        .tx_mclk(tx_mclk1), .tx_sclk(tx_sclk1), .tx_lrclk(tx_lrclk1), .tx_data(tx_data1),
        .frame_start(fs1), .underrun(ur1));

    i2s_tx_tdm #(.WIDTH(16), .SLOT_BITS(32), .CHANNELS(8), .MODE(1), .MCLK_DIV(2), .SCLK_DIV(8)) dut8 (
        .clk_i2s(clk), .reset(reset), .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
        .tx_mclk(tx_mclk8), .tx_sclk(tx_sclk8), .tx_lrclk(tx_lrclk8), .tx_data(tx_data8),
        .frame_start(fs8), .underrun(ur8));

    int tests = 0;
    int fails = 0;

    logic [63:0]  c0, c1, lr0, lr1;
    logic [255:0] c8, lr8;
    int us0, fs0_n, us8, fs8_n;
    int n;
    int sclk_r, sclk_hi, mclk_r, lr_t, ur_n, fs_n, ones;
    logic p_s, p_m, p_l;
    logic [63:0] exp_stall0, exp_stall1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_dut0"}, {tx_mclk0, tx_sclk0, tx_lrclk0, tx_data0, s_ready0, fs0, ur0}, 7'b0010100);
        check({tag, "_dut1"}, {tx_mclk1, tx_sclk1, tx_lrclk1, tx_data1, s_ready1, fs1, ur1}, 7'b0010100);
        check({tag, "_dut8"}, {tx_mclk8, tx_sclk8, tx_lrclk8, tx_data8, s_ready8, fs8, ur8}, 7'b0010100);
    endtask

    task automatic wait_fs0(input int lim, output int cnt);
        cnt = -1;
        for (int c = 1; c <= lim; c++) begin
            @(posedge clk); #1;
            if (fs0) begin
                cnt = c;
                break;
            end
        end
    endtask

    // Starts at the sample right after a load edge; one bit per SCLK_DIV cycles.
    task automatic capture(input int ncyc);
        c0 = '0; c1 = '0; lr0 = '0; lr1 = '0; c8 = '0; lr8 = '0;
        us0 = 0; fs0_n = 0; us8 = 0; fs8_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
            end
            if ((c % 8) == 0 && c < 512) begin
                c0[63 - c/8]  = tx_data0;
                c1[63 - c/8]  = tx_data1;
                lr0[63 - c/8] = tx_lrclk0;
                lr1[63 - c/8] = tx_lrclk1;
            end
            if ((c % 8) == 0 && c < 2048) begin
                c8[255 - c/8]  = tx_data8;
                lr8[255 - c/8] = tx_lrclk8;
            end
            us0   += int'(ur0);
            fs0_n += int'(fs0);
            us8   += int'(ur8);
            fs8_n += int'(fs8);
        end
    endtask

    initial begin
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_valid8 = 1'b0;
        s_data   = {24'h123456, 24'hA5A5A5};
        for (int k = 0; k < 8; k++) s_data8[k*16 +: 16] = 16'(16'h1111 * k);

        repeat (3) @(posedge clk); #1;
        chk_reset("rst_init");
        reset = 1'b0;

        // Idle source: clock periods, word-select cadence, underruns, silent data
        sclk_r = 0; sclk_hi = 0; mclk_r = 0; lr_t = 0; ur_n = 0; fs_n = 0; ones = 0;
        p_s = tx_sclk0; p_m = tx_mclk0; p_l = tx_lrclk0;
        for (int c = 0; c < 1024; c++) begin
            @(posedge clk); #1;
            if (tx_sclk0 && !p_s) sclk_r++;
            if (tx_mclk0 && !p_m) mclk_r++;
            if (tx_lrclk0 != p_l) lr_t++;
            sclk_hi += int'(tx_sclk0);
            ur_n    += int'(ur0);
            fs_n    += int'(fs0);
            ones    += int'(tx_data0) + int'(tx_data1);
            p_s = tx_sclk0; p_m = tx_mclk0; p_l = tx_lrclk0;
        end
        check("sclk_rises", sclk_r, 128);
        check("sclk_high", sclk_hi, 512);
        check("mclk_rises", mclk_r, 512);
        check("lrclk_toggles", lr_t, 4);
        check("idle_underruns", ur_n, 2);
        check("idle_frame_starts", fs_n, 2);
        check("idle_data_ones", ones, 0);

        // Held-valid stereo and TDM frames loaded from reset
        reset = 1'b1;
        s_valid  = 1'b1;
        s_valid8 = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        wait_fs0(20, n);
        check("first_load_latency", n, 8);
        check("first_load_no_underrun", {ur0, ur1, ur8, fs8}, 4'b0001);
        capture(2048);
        check("i2s_frame", c0, 64'h52D2D280091A2B00);
        check("lj_frame", c1, 64'hA5A5A50012345600);
        check("i2s_lrclk", lr0, 64'h00000000FFFFFFFF);
        check("lj_lrclk", lr1, 64'h00000000FFFFFFFF);
        check("held_underruns", us0, 0);
        check("stereo_frames_in_window", fs0_n, 4);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("tdm_slot%0d", k), c8[255 - 32*k -: 32], 32'(k) * 32'h11110000);
        end
        check("tdm_lrclk", lr8, {{128{1'b0}}, {128{1'b1}}});
        check("tdm_frames", fs8_n, 1);
        check("tdm_underruns", us8, 0);

        // Source stalls for one frame after the next load
        wait_fs0(20, n);
        check("stall_load_latency", n, 1);
        s_valid = 1'b0;
        ur_n = 0;
        for (int c = 0; c < 511; c++) begin
            @(posedge clk); #1;
            ur_n += int'(ur0);
        end
        check("stall_no_early_underrun", ur_n, 0);
        check("stall_ready", s_ready0, 1'b1);
        @(posedge clk); #1;
        check("stall_underrun_pulse", {fs0, ur0, ur1}, 3'b111);
        s_data  = {24'hC3C3C3, 24'h00FF00};
        s_valid = 1'b1;
        capture(512);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        exp_stall0 = 64'h52D2D280091A2B00;
        exp_stall1 = 64'hA5A5A50012345600;
`else
        exp_stall0 = 64'h0;
        exp_stall1 = 64'h0;
`endif
        check("stall_i2s_frame", c0, exp_stall0);
        check("stall_lj_frame", c1, exp_stall1);
        check("stall_underrun_count", us0, 1);
        check("stall_refilled", s_ready0, 1'b0);
        @(posedge clk); #1;
        check("resume_load", {fs0, ur0}, 2'b10);
        capture(512);
        check("resume_i2s_frame", c0, 64'h007F800061E1E180);
        check("resume_lj_frame", c1, 64'h00FF0000C3C3C300);
        check("resume_underruns", us0, 0);

        // Asynchronous reset at bit 40 of a frame
        @(posedge clk); #1;
        check("mid_frame_start", fs0, 1'b1);
        repeat (323) @(posedge clk); #1;
        check("mid_lrclk_right_half", tx_lrclk0, 1'b1);
        s_valid  = 1'b0;
        s_valid8 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_reset("rst_mid");
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        wait_fs0(20, n);
        check("post_reset_latency", n, 8);
        check("post_reset_flags", {ur0, fs8, ur8, tx_lrclk0}, 4'b1110);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
